// File: rtl/spm_mul_core_if.sv
// Operand/result bundle between the Wishbone front-end and the SPM core.
// No latency of its own; pure wiring.
// No backpressure: start is a one-shot request, done a one-shot response.
interface spm_mul_core_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     mc;
    logic [WIDTH-1:0]     mp;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   prod;

    // Front-end drives operands and start, core returns status and product
    modport master (output start, mc, mp, input busy, done, prod);
    modport slave  (input start, mc, mp, output busy, done, prod);
endinterface

// File: rtl/spm_mul_core.sv
// Serial-parallel multiplier: unsigned mc*mp, one product bit per clock, LSB first.
// Latency: start in cycle 0, busy cycles 1..2*WIDTH, done pulse in cycle 2*WIDTH+1.
// No backpressure: start is accepted only in IDLE or DONE and ignored while running.
module spm_mul_core #(
    parameter int WIDTH = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    spm_mul_core_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  mc_q, mc_d;
    logic [WIDTH-1:0]  mp_sr_q, mp_sr_d;
    // Sum flops hold the sums of slices 1..WIDTH-1, already aligned to the slice below
    logic [WIDTH-2:0]  s_q, s_d;
    logic [WIDTH-1:0]  c_q, c_d;
    // Product bits shifted out so far; the final bit comes straight from slice 0
    logic [PW-2:0]     psr_q, psr_d;
    logic [PW-1:0]     prod_q, prod_d;

    logic [WIDTH-1:0]  pp;
    logic [WIDTH-1:0]  s_in;
    logic [WIDTH-1:0]  sum_c;
    logic [WIDTH-1:0]  car_c;
    logic              accept;
    logic              last;
    logic              busy_c;
    logic              done_c;

    // mp_sr fills with zeros, so the serial bit is 0 once the multiplier is exhausted
    assign pp     = mc_q & {WIDTH{mp_sr_q[0]}};
    assign s_in   = {1'b0, s_q};
    assign sum_c  = pp ^ s_in ^ c_q;
    assign car_c  = (pp & s_in) | (pp & c_q) | (s_in & c_q);

    assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign last   = (count_q == CW'(PW - 1));

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = accept ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Carry-save row step, operand capture and product hand-off
    always_comb begin
        count_d = count_q;
        mc_d    = mc_q;
        mp_sr_d = mp_sr_q;
        s_d     = s_q;
        c_d     = c_q;
        psr_d   = psr_q;
        prod_d  = prod_q;
        if (accept) begin
            mc_d    = bus.mc;
            mp_sr_d = bus.mp;
            s_d     = '0;
            c_d     = '0;
            psr_d   = '0;
            count_d = '0;
        end else if (state_q == RUN) begin
            mp_sr_d = mp_sr_q >> 1;
            s_d     = sum_c[WIDTH-1:1];
            c_d     = car_c;
            psr_d   = {sum_c[0], psr_q[PW-2:1]};
            count_d = last ? '0 : count_q + CW'(1);
            // Result is published only once all bits are in
            if (last) prod_d = {sum_c[0], psr_q};
        end
    end

    // Datapath registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            count_q <= '0;
            mc_q    <= '0;
            mp_sr_q <= '0;
            s_q     <= '0;
            c_q     <= '0;
            psr_q   <= '0;
            prod_q  <= '0;
        end else begin
            count_q <= count_d;
            mc_q    <= mc_d;
            mp_sr_q <= mp_sr_d;
            s_q     <= s_d;
            c_q     <= c_d;
            psr_q   <= psr_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.prod = prod_q;
endmodule
